// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned RESET_PC_DEFAULT = 0;
    localparam int unsigned PC_STEP          = 4;

    // One fetched word as handed to decode; sized by XLEN_DEFAULT, so the top XLEN must match.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
        logic                    fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; producer must not push when full without a pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

    assign head  = entries[rd_ptr];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, 1-cycle synchronous IMEM, output queue to decode, redirect/flush and preload port.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned IMEM_DEPTH  = 64,
    parameter int unsigned RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic                          out_fault,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [XLEN-1:0]               load_data
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [XLEN-1:0] pc_q;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic            inflight_fault_q;
    logic [XLEN-1:0] rd_data_q;
    logic [XLEN-1:0] mem [IMEM_DEPTH];

    fetch_entry_t    push_entry;
    fetch_entry_t    q_head;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;

    logic            pop_c;
    logic            push_c;
    logic            issue_c;
    logic            in_range_c;
    logic [OW-1:0]   occ_c;

    // Entries already owned (queued plus in flight) after this cycle's pop decide whether a new fetch fits.
    assign pop_c      = out_valid && out_ready;
    assign occ_c      = OW'(q_count) + OW'(inflight_q) - OW'(pop_c);
    assign issue_c    = !redirect_valid && (occ_c < OW'(QUEUE_DEPTH));
    assign in_range_c = (pc_q < XLEN'(IMEM_DEPTH * PC_STEP));
    assign push_c     = inflight_q && !redirect_valid && (!q_full || pop_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q             <= XLEN'(RESET_PC);
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_fault_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc & ~XLEN'(3);
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            if (issue_c) begin
                inflight_pc_q    <= pc_q;
                inflight_fault_q <= !in_range_c;
                pc_q             <= pc_q + XLEN'(PC_STEP);
            end
        end
    end

    // Registered read sees the pre-write word when a load hits the same address on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(IMEM_DEPTH); i++) mem[i] <= '0;
            rd_data_q <= '0;
        end else begin
            if (load_en) mem[load_addr] <= load_data;
            if (issue_c) rd_data_q <= in_range_c ? mem[pc_q[AW+1:2]] : '0;
        end
    end

    assign push_entry = '{pc: inflight_pc_q, instr: rd_data_q, fault: inflight_fault_q};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign out_valid = !q_empty;
    assign out_pc    = q_head.pc;
    assign out_instr = q_head.instr;
    assign out_fault = q_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a fetch-stream model.
module tb_fetch_unit;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned QD         = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [31:0]     out_pc;
    logic            out_fault;
    logic            load_en;
    logic [5:0]      load_addr;
    logic [31:0]     load_data;

    logic [31:0]     mem_m [IMEM_DEPTH];
    logic [65:0]     obs;
    int              vectors     = 0;
    int              miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN        (XLEN),
        .IMEM_DEPTH  (IMEM_DEPTH),
        .RESET_PC    (0),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data)
    );

    assign obs = {out_valid, out_pc, out_instr, out_fault};

    // What decode should see for a fetch of pc: {valid, pc, instr, fault}.
    function automatic logic [65:0] ref_entry(input logic [31:0] pc);
        logic flt;
        flt = (pc >= 32'(IMEM_DEPTH * 4));
        return {1'b1, pc, flt ? 32'h0 : mem_m[pc[7:2]], flt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(IMEM_DEPTH); i++) mem_m[i] = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        clear_model();
        #12;
        vectors++;
        if (obs !== 66'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", obs, 66'h0);
        end
        @(posedge clk); #1; reset = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cycle1_empty: got %b want 0", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (obs !== ref_entry(32'(4 * k))) begin
                miscompares++;
                $display("FAIL reset_first_stream[%0d]: got %h want %h", k, obs, ref_entry(32'(4 * k)));
            end
        end
    endtask

    task automatic test_preload_stream();
        redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        for (int i = 0; i < int'(IMEM_DEPTH); i++) begin
            load_en   = 1'b1;
            load_addr = 6'(i);
            load_data = (i < 4) ? 32'(32'h11 * (i + 1)) : (i == 5) ? 32'h55 : $urandom;
            mem_m[i]  = load_data;
            tick();
        end
        load_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL preload_gap: got %b want 0", out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if (obs !== ref_entry(32'(4 * k))) begin
                miscompares++;
                $display("FAIL preload_stream[%0d]: got %h want %h", k, obs, ref_entry(32'(4 * k)));
            end
        end
    endtask

    task automatic test_backpressure();
        redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (obs !== ref_entry(32'h0)) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %h want %h", k, obs, ref_entry(32'h0));
            end
            if (k < 5) tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            vectors++;
            if (obs !== ref_entry(32'(4 * k))) begin
                miscompares++;
                $display("FAIL bp_release[%0d]: got %h want %h", k, obs, ref_entry(32'(4 * k)));
            end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h8; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick(); tick();
        vectors++;
        if (obs !== ref_entry(32'h8)) begin
            miscompares++;
            $display("FAIL rd_setup: got %h want %h", obs, ref_entry(32'h8));
        end
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_flush: got %b want 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_gap: got %b want 0", out_valid);
        end
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (obs !== ref_entry(32'(32'h20 + 4 * k))) begin
                miscompares++;
                $display("FAIL rd_target[%0d]: got %h want %h", k, obs, ref_entry(32'(32'h20 + 4 * k)));
            end
            tick();
        end
    endtask

    task automatic test_out_of_range();
        redirect_valid = 1'b1; redirect_pc = 32'hF0; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (obs !== ref_entry(32'(32'hF0 + 4 * k))) begin
                miscompares++;
                $display("FAIL oor_stream[%0d]: got %h want %h", k, obs, ref_entry(32'(32'hF0 + 4 * k)));
            end
        end
    endtask

    task automatic test_load_collision();
        redirect_valid = 1'b1; redirect_pc = 32'd20; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'hABCD;
        tick();
        load_en = 1'b0;
        tick();
        vectors++;
        if (obs !== ref_entry(32'd20)) begin
            miscompares++;
            $display("FAIL load_old_word: got %h want %h", obs, ref_entry(32'd20));
        end
        mem_m[5] = 32'hABCD;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        vectors++;
        if (obs !== ref_entry(32'd20)) begin
            miscompares++;
            $display("FAIL load_new_word: got %h want %h", obs, ref_entry(32'd20));
        end
    endtask

    task automatic test_random();
        logic [31:0] next_pc;
        logic [31:0] tgt;
        logic [5:0]  la;
        logic [31:0] ld;
        logic        redir;
        logic        do_load;
        int          since;
        next_pc = '0;
        since   = 0;
        for (int i = 0; i < 800; i++) begin
            out_ready = ($urandom % 10) < 7;
            redir     = (i == 0) || (($urandom % 20) == 0);
            do_load   = redir && ($urandom % 2 == 1);
            if (i > 0) begin
                vectors++;
                if (out_valid !== (since > 2)) begin
                    miscompares++;
                    $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, since > 2);
                end
                if (out_valid && out_ready) begin
                    vectors++;
                    if (obs !== ref_entry(next_pc)) begin
                        miscompares++;
                        $display("FAIL rand_stream[%0d]: got %h want %h", i, obs, ref_entry(next_pc));
                    end
                    next_pc = next_pc + 32'd4;
                end
            end
            tgt            = 32'($urandom_range(0, 75) * 4 + $urandom_range(0, 3));
            la             = 6'($urandom_range(0, 63));
            ld             = $urandom;
            redirect_valid = redir;
            redirect_pc    = tgt;
            load_en        = do_load;
            load_addr      = la;
            load_data      = ld;
            tick();
            if (redir) begin
                next_pc = tgt & ~32'h3;
                since   = 1;
                if (do_load) mem_m[la] = ld;
            end else begin
                since++;
            end
        end
        redirect_valid = 1'b0;
        load_en        = 1'b0;
    endtask

    task automatic test_reset_midstream();
        redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick(); tick();
        vectors++;
        if (obs !== ref_entry(32'h0)) begin
            miscompares++;
            $display("FAIL mid_setup: got %h want %h", obs, ref_entry(32'h0));
        end
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_pc} !== 33'h0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %h want 0", {out_valid, out_pc});
        end
        clear_model();
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_restart_gap: got %b want 0", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (obs !== ref_entry(32'(4 * k))) begin
                miscompares++;
                $display("FAIL mid_restart[%0d]: got %h want %h", k, obs, ref_entry(32'(4 * k)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload_stream();
        test_backpressure();
        test_redirect();
        test_out_of_range();
        test_load_collision();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
